// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the IO transaction FSM state type, the default MMIO window base and
// ack timeout, the word returned on a timed-out IO read, and a byte-lane
// masking helper used wherever read data must zero its disabled lanes.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_e;

    localparam logic [31:0] IO_BASE_DEFAULT    = 32'hFFFF_FF00;
    localparam int unsigned IO_TIMEOUT_DEFAULT = 32'd255;
    localparam logic [31:0] IO_ERR_WORD        = 32'hDEAD_BEEF;

    // Zero every byte lane whose enable bit is clear.
    function automatic logic [31:0] lane_mask(input logic [31:0] data, input logic [3:0] en);
        logic [31:0] res;
        res = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = en[i] ? data[8*i +: 8] : 8'h00;
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-addressed RAM built from four independent 8-bit lanes.
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset (clears only the read register)
//   idx      - word index
//   wdata    - store data, lane i on bits [8i+7:8i]
//   we       - per-lane write enable
//   rd_en    - load the read register this cycle
//   rd_lanes - lanes to return; disabled lanes read as zero
//   rdata    - registered read data (held between reads)
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
    input  logic [31:0]                    wdata,
    input  logic [3:0]                     we,
    input  logic                           rd_en,
    input  logic [3:0]                     rd_lanes,
    output logic [31:0]                    rdata
);

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] mem_r [DEPTH_WORDS];
        logic [7:0] q_r;

        // Lane storage write port; contents deliberately survive reset.
        always_ff @(posedge clk) begin
            if (we[g]) begin
                mem_r[idx] <= wdata[8*g +: 8];
            end
        end

        // Lane read register, loaded only on a read so it holds otherwise.
        always_ff @(posedge clk) begin
            if (rst) begin
                q_r <= 8'h00;
            end else if (rd_en) begin
                q_r <= rd_lanes[g] ? mem_r[idx] : 8'h00;
            end
        end

        assign rdata[8*g +: 8] = q_r;
    end

endmodule

// File: rtl/dmem_responder.sv
// CPU data-memory responder: single-cycle RAM plus a stalling MMIO bridge.
// Accesses below the MMIO window go to a byte-lane RAM with 1-cycle read
// latency and never stall. Accesses inside the 256-byte window at IO_BASE
// stall the CPU while a latched request is presented to a peripheral until
// io_ack or an IO_TIMEOUT-cycle timeout (sticky io_err, read returns DEADBEEF).
// Ports:
//   clk, rst                  - clock and synchronous active-high reset
//   data_mem_addr/write_data  - CPU byte address and store data
//   data_mem_wr/en            - per-byte write strobes and enables
//   data_mem_data             - read data, held until the next completed read
//   mem_stall                 - CPU must hold its request (combinational)
//   io_req/we/addr/wdata/be   - peripheral request, held stable while pending
//   io_ack/io_rdata           - peripheral completion pulse and read data
//   io_err                    - sticky timeout flag
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] IO_BASE     = IO_BASE_DEFAULT,
    parameter int unsigned IO_TIMEOUT  = IO_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_mem_addr,
    input  logic [31:0] data_mem_write_data,
    input  logic [3:0]  data_mem_wr,
    input  logic [3:0]  data_mem_en,
    output logic [31:0] data_mem_data,
    output logic        mem_stall,
    output logic        io_req,
    output logic        io_we,
    output logic [7:0]  io_addr,
    output logic [31:0] io_wdata,
    output logic [3:0]  io_be,
    input  logic        io_ack,
    input  logic [31:0] io_rdata,
    output logic        io_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = $clog2(IO_TIMEOUT + 1);

    dmem_state_e   state_r;
    dmem_state_e   state_next_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_inc_s;
    logic          io_hit_s;
    logic          access_s;
    logic          stall_s;
    logic          start_s;
    logic          ack_s;
    logic          tmo_s;
    logic [3:0]    ram_we_s;
    logic          ram_rd_s;
    logic          sel_io_r;
    logic [31:0]   io_data_r;
    logic [31:0]   bank_rdata_s;

    assign io_hit_s  = (data_mem_addr[31:8] == IO_BASE[31:8]);
    assign access_s  = (data_mem_en != 4'b0000);
    assign cnt_inc_s = cnt_r + CW'(1);

    // The result register is split: RAM reads land in the bank, IO reads in
    // io_data_r; sel_io_r remembers which one completed last.
    assign data_mem_data = sel_io_r ? io_data_r : bank_rdata_s;

    // RAM port decode: only served while idle and out of reset.
    always_comb begin
        ram_we_s = 4'b0000;
        ram_rd_s = 1'b0;
        if (!rst && (state_r == ST_IDLE) && access_s && !io_hit_s) begin
            ram_we_s = data_mem_en & data_mem_wr;
            ram_rd_s = (data_mem_wr == 4'b0000);
        end else begin
            ram_we_s = 4'b0000;
            ram_rd_s = 1'b0;
        end
    end

    dmem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .idx      (data_mem_addr[AW+1:2]),
        .wdata    (data_mem_write_data),
        .we       (ram_we_s),
        .rd_en    (ram_rd_s),
        .rd_lanes (data_mem_en),
        .rdata    (bank_rdata_s)
    );

    // IO FSM next-state and stall decode.
    always_comb begin
        state_next_s = state_r;
        stall_s      = 1'b0;
        start_s      = 1'b0;
        ack_s        = 1'b0;
        tmo_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (access_s && io_hit_s) begin
                    stall_s      = 1'b1;
                    start_s      = 1'b1;
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                stall_s = 1'b1;
                // An ack in the final allowed cycle beats the timeout.
                if (io_ack) begin
                    ack_s        = 1'b1;
                    state_next_s = ST_DONE;
                end else if (cnt_inc_s == CW'(IO_TIMEOUT)) begin
                    tmo_s        = 1'b1;
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Stall output, suppressed while reset is held.
    always_comb begin
        mem_stall = 1'b0;
        if (rst) begin
            mem_stall = 1'b0;
        end else begin
            mem_stall = stall_s;
        end
    end

    // IO FSM state, request latches, wait counter, IO result and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            io_req    <= 1'b0;
            io_we     <= 1'b0;
            io_addr   <= 8'h00;
            io_wdata  <= 32'h0000_0000;
            io_be     <= 4'b0000;
            io_err    <= 1'b0;
            io_data_r <= 32'h0000_0000;
            sel_io_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            io_req  <= (state_next_s == ST_REQ);
            if (start_s) begin
                io_addr  <= data_mem_addr[7:0];
                io_wdata <= data_mem_write_data;
                io_be    <= data_mem_en;
                io_we    <= |(data_mem_wr & data_mem_en);
                cnt_r    <= '0;
            end else if (state_r == ST_REQ) begin
                cnt_r <= cnt_inc_s;
            end
            if (ack_s && !io_we) begin
                io_data_r <= lane_mask(io_rdata, io_be);
                sel_io_r  <= 1'b1;
            end
            if (tmo_s) begin
                io_err <= 1'b1;
                if (!io_we) begin
                    io_data_r <= IO_ERR_WORD;
                    sel_io_r  <= 1'b1;
                end
            end
            if (ram_rd_s) begin
                sel_io_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a reference word array and a
// scoreboard queue of expected data_mem_data values, pushed when a request
// is driven and popped when the DUT completes it.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned TMO   = 16;
    localparam logic [31:0] BASE  = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wr;
    logic [3:0]  en;
    logic [31:0] data;
    logic        stall;
    logic        io_req;
    logic        io_we;
    logic [7:0]  io_addr;
    logic [31:0] io_wdata;
    logic [3:0]  io_be;
    logic        io_ack;
    logic [31:0] io_rdata;
    logic        io_err;

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .IO_BASE     (BASE),
        .IO_TIMEOUT  (TMO)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .data_mem_addr       (addr),
        .data_mem_write_data (wdata),
        .data_mem_wr         (wr),
        .data_mem_en         (en),
        .data_mem_data       (data),
        .mem_stall           (stall),
        .io_req              (io_req),
        .io_we               (io_we),
        .io_addr             (io_addr),
        .io_wdata            (io_wdata),
        .io_be               (io_be),
        .io_ack              (io_ack),
        .io_rdata            (io_rdata),
        .io_err              (io_err)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] exp_q [$];
    logic [31:0] exp_data = 32'h0000_0000;
    logic        exp_err  = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bmask(input logic [31:0] d, input logic [3:0] e);
        logic [31:0] r;
        r = 32'h0000_0000;
        for (int i = 0; i < 4; i++) if (e[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic sb_check(input string tag);
        logic [31:0] e;
        e = 32'hxxxx_xxxx;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        check(tag, {32'h0, data}, {32'h0, e});
    endtask

    task automatic ram_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        int unsigned idx;
        idx = (a >> 2) % DEPTH;
        addr = a; wdata = d; wr = w; en = w;
        #1 check("ram_wr_stall", {63'h0, stall}, 64'h0);
        for (int i = 0; i < 4; i++) if (w[i]) model[idx][8*i +: 8] = d[8*i +: 8];
        exp_q.push_back(exp_data);
        @(posedge clk); #1;
        wr = 4'h0; en = 4'h0;
        sb_check("ram_wr_hold");
    endtask

    task automatic ram_read(input logic [31:0] a, input logic [3:0] e);
        int unsigned idx;
        idx = (a >> 2) % DEPTH;
        addr = a; wr = 4'h0; en = e;
        #1 check("ram_rd_stall", {63'h0, stall}, 64'h0);
        exp_data = bmask(model[idx], e);
        exp_q.push_back(exp_data);
        @(posedge clk); #1;
        en = 4'h0;
        sb_check("ram_rd_data");
    endtask

    // ack_at = REQ cycle (1-based) in which io_ack is pulsed; 0 = never.
    task automatic io_access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                             input logic [3:0] e, input int ack_at, input logic [31:0] rd);
        logic is_wr;
        logic tmo;
        logic done;
        int   exp_req;
        int   req_cycles;
        int   stall_cnt;
        int   bursts;
        logic prev_req;
        is_wr   = |(w & e);
        tmo     = !(ack_at >= 1 && ack_at <= int'(TMO));
        exp_req = tmo ? int'(TMO) : ack_at;
        addr = a; wdata = d; wr = w; en = e;
        #1 check("io_idle_stall", {63'h0, stall}, 64'h1);
        if (!is_wr) exp_data = tmo ? 32'hDEAD_BEEF : bmask(rd, e);
        exp_q.push_back(exp_data);
        if (tmo) exp_err = 1'b1;
        stall_cnt = 1; req_cycles = 0; bursts = 0; prev_req = 1'b0; done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(posedge clk); #1;
            if (io_req) begin
                req_cycles++;
                if (!prev_req) bursts++;
                check("io_fields", {19'h0, io_we, io_be, io_addr, io_wdata},
                      {19'h0, is_wr, e, a[7:0], d});
            end
            prev_req = io_req;
            io_ack   = io_req && (req_cycles == ack_at);
            io_rdata = io_ack ? rd : $urandom;
            #1;
            if (stall) stall_cnt++;
            else done = 1'b1;
        end
        check("io_done_budget", {63'h0, stall}, 64'h0);
        sb_check("io_data");
        io_ack = 1'b0; en = 4'h0; wr = 4'h0;
        @(posedge clk); #1;
        if (io_req && !prev_req) bursts++;
        check("io_req_cycles", 64'(req_cycles), 64'(exp_req));
        check("io_stall_cycles", 64'(stall_cnt), 64'(exp_req + 1));
        check("io_bursts", 64'(bursts), 64'd1);
        check("io_err", {63'h0, io_err}, {63'h0, exp_err});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; addr = BASE | 32'h4; wdata = 32'h0; wr = 4'h0; en = 4'hF;
        io_ack = 1'b0; io_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_stall", {63'h0, stall}, 64'h0);
        check("rst_ctrl", {48'h0, io_req, io_we, io_be, io_addr, io_err, 1'b0},
              64'h0);
        check("rst_wdata", {32'h0, io_wdata}, 64'h0);
        check("rst_data", {32'h0, data}, 64'h0);
        rst = 1'b0; en = 4'h0;
        @(posedge clk); #1;

        // Reset during the second REQ cycle aborts the IO read.
        addr = BASE + 32'h8; en = 4'hF; wr = 4'h0;
        #1 check("abort_idle_stall", {63'h0, stall}, 64'h1);
        @(posedge clk); #1;
        check("abort_req1", {63'h0, io_req}, 64'h1);
        @(posedge clk); #1;
        check("abort_req2", {63'h0, io_req}, 64'h1);
        rst = 1'b1;
        #1 check("abort_rst_stall", {63'h0, stall}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0; en = 4'h0;
        #1;
        check("abort_req_off", {63'h0, io_req}, 64'h0);
        check("abort_stall_off", {63'h0, stall}, 64'h0);
        io_ack = 1'b1; io_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        io_ack = 1'b0;
        check("abort_late_ack_req", {63'h0, io_req}, 64'h0);
        check("abort_late_ack_data", {32'h0, data}, 64'h0);

        // Full-word and single-lane RAM traffic.
        ram_write(32'h10, 32'hAABB_CCDD, 4'hF);
        ram_read(32'h10, 4'hF);
        ram_write(32'h10, 32'h0000_1100, 4'b0010);
        ram_read(32'h10, 4'hF);
        ram_read(32'h10, 4'b0001);

        // Random words with random lane masks; addr[1:0] must be ignored.
        for (int k = 0; k < 8; k++) begin
            logic [31:0] ra;
            ra = {16'h0, 16'($urandom_range(0, 16'hFFFF))};
            ram_write(ra, $urandom, 4'hF);
            ram_write(ra ^ 32'h3, $urandom, 4'($urandom_range(1, 15)));
            ram_read(ra, 4'($urandom_range(1, 15)));
        end

        // Address aliasing above the RAM depth.
        ram_write(32'h4, 32'h0BAD_F00D, 4'hF);
        ram_read(32'h4 + DEPTH * 4, 4'hF);

        // io_ack while idle is ignored.
        io_ack = 1'b1; io_rdata = 32'h5555_AAAA;
        exp_q.push_back(exp_data);
        @(posedge clk); #1;
        io_ack = 1'b0;
        check("idle_ack_req", {63'h0, io_req}, 64'h0);
        sb_check("idle_ack_data");

        io_access(BASE + 32'h04, 32'h0, 4'h0, 4'hF, 3, 32'h1234_5678);
        io_access(BASE + 32'hFC, 32'h0, 4'h0, 4'b1100, int'(TMO), 32'h89AB_CDEF);
        io_access(BASE + 32'h80, 32'hA5A5_5A5A, 4'b0011, 4'b0011, 2, 32'h7777_7777);
        io_access(BASE + 32'h10, 32'h1122_3344, 4'hF, 4'hF, 0, 32'h0);
        io_access(BASE + 32'h20, 32'h0, 4'h0, 4'hF, 0, 32'h0);

        // RAM read after IO results, with the error flag still set.
        ram_read(32'h10, 4'hF);
        check("err_sticky", {63'h0, io_err}, 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 4096, giving the RAM depth in 32-bit words (power of two).
REQ-002 The block SHALL have parameter IO_BASE, default 32'hFFFF_FF00, giving the base of a 256-byte MMIO window.
REQ-003 The block SHALL have parameter IO_TIMEOUT, default 255, giving the maximum cycles to wait for io_ack.
REQ-004 Port list, in order:
  - clk  in  1  sole clock, rising edge
  - rst  in  1  synchronous, active-high reset
  - data_mem_addr  in  32  byte address from the CPU
  - data_mem_write_data  in  32  store data
  - data_mem_wr  in  4  per-byte write strobes
  - data_mem_en  in  4  per-byte enables
  - data_mem_data  out  32  registered read data
  - mem_stall  out  1  CPU must hold its request
  - io_req  out  1  peripheral request
  - io_we  out  1  peripheral write
  - io_addr  out  8  MMIO byte offset
  - io_wdata  out  32  peripheral write data
  - io_be  out  4  peripheral byte enables
  - io_ack  in  1  peripheral done, one-cycle pulse
  - io_rdata  in  32  peripheral read data, valid with io_ack
  - io_err  out  1  sticky timeout flag
REQ-005 The block SHALL use one clock (clk) and a synchronous active-high reset (rst).

Function
REQ-006 An access SHALL be any cycle with data_mem_en != 0.
REQ-007 An access SHALL be an IO hit when data_mem_addr[31:8] == IO_BASE[31:8]; otherwise it SHALL be a RAM access.
REQ-008 RAM write: lane i SHALL be written when data_mem_en[i] & data_mem_wr[i]; data_mem_data SHALL be unchanged.
REQ-009 RAM read (data_mem_wr == 0): data_mem_data SHALL present the word on the next rising edge (1-cycle latency), with bytes where en=0 reading as 8'h00.
REQ-010 RAM word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher bits alias, addr[1:0] are ignored, and accesses never stall.
REQ-011 The FSM SHALL have states IDLE, REQ and DONE, and reset to IDLE.
REQ-012 In IDLE on an IO hit: mem_stall=1 combinationally that cycle; latch addr[7:0], write_data, en, and we=|(wr&en); next state REQ.
REQ-013 In REQ: io_req=1, io_* SHALL be driven from the latches and held stable, mem_stall=1, and the wait counter SHALL increment.
REQ-014 In REQ on io_ack: a read SHALL load data_mem_data with io_rdata (lanes with en=0 zeroed) and a write SHALL leave it unchanged; next state DONE.
REQ-015 In REQ, when the counter reaches IO_TIMEOUT without io_ack: io_err<=1, a read SHALL return 32'hDEAD_BEEF, and the next state SHALL be DONE.
REQ-016 In DONE: mem_stall=0, io_req=0, bus inputs ignored (the held request has completed); next state IDLE unconditionally.
REQ-017 io_ack outside REQ SHALL be ignored.
REQ-018 io_ack in the same cycle the timeout is reached SHALL win: no error, data taken.
REQ-019 data_mem_data SHALL hold its value until the next completed read.
REQ-020 io_err SHALL be sticky and cleared only by rst.

Reset
REQ-021 On rst: state=IDLE, counter=0, data_mem_data=0, io_req=0, io_we=0, io_addr=0, io_wdata=0, io_be=0, io_err=0; mem_stall SHALL be forced 0 while rst=1.
REQ-022 rst in REQ SHALL abort the transaction: io_req=0 from the next cycle, with no data returned.
REQ-023 RAM contents SHALL NOT be reset.

Structure
REQ-024 Shared package dmem_pkg SHALL hold the FSM state enum, the IO_BASE default, the IO_TIMEOUT default, and the 32'hDEAD_BEEF error constant.
REQ-025 One sub-module SHALL be used: dmem_bank, four 8-bit lanes of DEPTH_WORDS entries with per-lane write enable and a registered read.

Verification
REQ-026 Write addr 0x10, data 0xAABBCCDD, wr=en=4'hF; then read addr 0x10 with en=4'hF -> data_mem_data=0xAABBCCDD one cycle later, mem_stall never high.
REQ-027 Write addr 0x10, wr=en=4'b0010, data 0x00001100 over 0xAABBCCDD; then read with en=4'hF -> 0xAABB11DD; read with en=4'b0001 -> 0x000000DD.
REQ-028 Read addr 0xFFFF_FF04 with io_ack after 3 REQ cycles and io_rdata=0x12345678 -> io_addr=0x04, mem_stall high 4 cycles, data_mem_data=0x12345678 in DONE, exactly one io_req burst.
REQ-029 IO write with no io_ack -> io_req high IO_TIMEOUT cycles, then io_err=1, stall drops, next IO read also times out -> 0xDEADBEEF.
REQ-030 rst asserted in the 2nd REQ cycle -> io_req=0 and mem_stall=0 next cycle; a later io_ack is ignored; state=IDLE.
REQ-031 Read addr 0x4 + DEPTH_WORDS*4 -> returns the word at addr 0x4 (aliasing).
